lvds_align_ctrl: RTL
====================

Name: lvds_align_ctrl

Overview:
- Link-training controller for the 8-bit LVDS TX/RX serdes pair.
- Waits for both PLL locks to be stable, then drives a fixed training word into the transmitter. It pulses the receiver's rx_data_align (bitslip) until the received word matches, then hands the TX/RX datapath to the user.
- Sits between user logic and the serdes.
- tx_coreclock and the parallel RX word share one clock domain, clk.

Parameters:
- WORD_W, 8, serdes parallel word width.
- TRAIN_PAT, 8'hF1, training word; all 8 rotations are distinct.
- LOCK_STABLE, 64, cycles both locks must stay high before training starts.
- CHECK_LEN, 16, consecutive matching words required to declare alignment.
- SLIP_HOLD, 2, cycles rx_data_align is held high per slip.
- SLIP_WAIT, 8, cycles ignored after a slip while the serdes output settles.
- MAX_SLIPS, 16, slips without success before declaring failure (2x WORD_W).

Ports:
- clk  in  1  core clock (tx_coreclock domain).
- rst_n  in  1  synchronous active-low reset.
- tx_locked  in  1  TX PLL lock.
- rx_locked  in  1  RX PLL lock.
- rx_data  in  WORD_W  parallel word from the LVDS receiver.
- user_tx_data  in  WORD_W  payload to transmit once the link is up.
- retrain  in  1  single-cycle request to restart training.
- tx_data  out  WORD_W  word to the LVDS transmitter tx_in.
- rx_data_align  out  1  bitslip strobe to the receiver.
- link_up  out  1  alignment achieved.
- link_fail  out  1  MAX_SLIPS exhausted.
- rx_user_data  out  WORD_W  registered rx_data, valid when rx_user_valid is high.
- rx_user_valid  out  1  equals link_up delayed one cycle together with the data.
- slip_count  out  5  slips issued in the current training attempt.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, tx_data=TRAIN_PAT, rx_data_align=0, link_up=0, link_fail=0, rx_user_valid=0, rx_user_data=0, slip_count=0, all counters 0.
- Reset mid-operation aborts training or data mode on the same edge.
- Outputs are registered. tx_data=TRAIN_PAT in every state except ALIGNED, where tx_data=user_tx_data with 1-cycle latency.
- IDLE: the lock counter counts while tx_locked&rx_locked; any drop clears it to 0. When the counter reaches LOCK_STABLE-1 -> TRAIN, with match counter and slip_count cleared.
- TRAIN: compares rx_data against TRAIN_PAT each cycle.
  - On a match, the match counter increments; reaching CHECK_LEN -> ALIGNED, link_up=1 on the next cycle.
  - On a mismatch: if slip_count==MAX_SLIPS -> FAIL; else -> SLIP, slip_count+1, match counter cleared.
- SLIP: rx_data_align=1 for exactly SLIP_HOLD cycles, then 0 -> SLIPWAIT.
- SLIPWAIT: ignores rx_data for SLIP_WAIT cycles -> TRAIN.
- ALIGNED: link_up=1; rx_user_data<=rx_data and rx_user_valid<=1 every cycle. No pattern checking is done in data mode.
- FAIL: link_fail=1, link_up=0. tx_data stays TRAIN_PAT. The block holds here until retrain or lock loss.
- Lock loss: from any state other than IDLE, if tx_locked=0 or rx_locked=0:
  - next state=IDLE; link_up, link_fail, rx_user_valid and rx_data_align clear on that edge.
  - Lock loss takes priority over every other transition.
- retrain: from TRAIN/SLIP/SLIPWAIT/ALIGNED/FAIL -> IDLE; rx_data_align, link_up, link_fail and rx_user_valid clear on that edge, and the lock counter restarts. Ignored in IDLE. Lock loss and retrain in the same cycle resolve as lock loss (both go to IDLE).
- rx_data_align never pulses outside SLIP. Consecutive slips are separated by at least SLIP_WAIT+1 low cycles.
- Counters saturate; none wrap.

Decomposition:
- Package lvds_align_pkg:
  - state enum/localparams: IDLE=0, TRAIN=1, SLIP=2, SLIPWAIT=3, ALIGNED=4, FAIL=5.
  - default TRAIN_PAT.
  - counter width function (clog2).
- One sub-module, lvds_pattern_check: compares rx_data against the pattern, provides the consecutive-match counter with clear input, and outputs match and done (done when the counter reaches CHECK_LEN).
- The FSM, slip timer and lock filter stay in the top module.

Test Plan:
- Locks high from cycle 0; RX model already aligned (rx_data=tx_data) -> link_up after LOCK_STABLE+CHECK_LEN+2 cycles; slip_count=0; rx_data_align never pulses.
- RX model rotates the word by 3 bits, undoing 1 bit per slip pulse (seen 0x8F for 0xF1) -> exactly 3 slip pulses, each 2 cycles wide; link_up asserts; slip_count=3.
- RX model never matches (constant 0x00) -> 16 slip pulses, then link_fail=1, link_up=0, tx_data=0xF1 held.
- In ALIGNED, drive user_tx_data 0xF1,0x22,0xF1,0x22 -> tx_data follows 1 cycle later; rx_user_data/rx_user_valid track the looped-back data.
- Drop rx_locked for 1 cycle while ALIGNED -> link_up=0 next edge, state_o=IDLE, full retraining succeeds; repeat with a retrain pulse from FAIL -> recovers.
- Assert rst_n=0 during a SLIP pulse -> rx_data_align=0 and all outputs at reset values on that edge.

Source files
------------

// File: rtl/lvds_align_pkg.sv
// rtl/lvds_align_pkg.sv - shared state encoding, defaults and helpers for LVDS link training
package lvds_align_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TRAIN    = 3'd1,
    SLIP     = 3'd2,
    SLIPWAIT = 3'd3,
    ALIGNED  = 3'd4,
    FAIL     = 3'd5
  } align_state_t;

  localparam logic [7:0] DEFAULT_TRAIN_PAT = 8'hF1;

  // Bits needed to hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lvds_pattern_check.sv
// rtl/lvds_pattern_check.sv - training word comparator with consecutive-match counter
module lvds_pattern_check
  import lvds_align_pkg::*;
#(
  parameter int                WORD_W    = 8,
  parameter logic [WORD_W-1:0] PATTERN   = WORD_W'(DEFAULT_TRAIN_PAT),
  parameter int                CHECK_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [WORD_W-1:0] rx_data,
  output logic              match,
  output logic              done
);

  localparam int CW = cnt_width(CHECK_LEN);

  logic [CW-1:0] match_cnt;

  assign match = (rx_data == PATTERN);
  assign done  = (match_cnt == CW'(CHECK_LEN));

  // Any mismatch restarts the run; the count parks at CHECK_LEN.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      match_cnt <= '0;
    end else if (!match) begin
      match_cnt <= '0;
    end else if (!done) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lvds_align_ctrl.sv
// rtl/lvds_align_ctrl.sv - LVDS serdes link-training controller: lock filter, bitslip FSM, data handoff
module lvds_align_ctrl
  import lvds_align_pkg::*;
#(
  parameter int                WORD_W      = 8,
  parameter logic [WORD_W-1:0] TRAIN_PAT   = WORD_W'(DEFAULT_TRAIN_PAT),
  parameter int                LOCK_STABLE = 64,
  parameter int                CHECK_LEN   = 16,
  parameter int                SLIP_HOLD   = 2,
  parameter int                SLIP_WAIT   = 8,
  parameter int                MAX_SLIPS   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_locked,
  input  logic              rx_locked,
  input  logic [WORD_W-1:0] rx_data,
  input  logic [WORD_W-1:0] user_tx_data,
  input  logic              retrain,
  output logic [WORD_W-1:0] tx_data,
  output logic              rx_data_align,
  output logic              link_up,
  output logic              link_fail,
  output logic [WORD_W-1:0] rx_user_data,
  output logic              rx_user_valid,
  output logic [4:0]        slip_count,
  output logic [2:0]        state_o
);

  localparam int LOCK_W = cnt_width(LOCK_STABLE - 1);
  localparam int TMR_W  = cnt_width((SLIP_HOLD > SLIP_WAIT) ? SLIP_HOLD : SLIP_WAIT);

  align_state_t      state, next_state;
  logic [LOCK_W-1:0] lock_cnt;
  logic [TMR_W-1:0]  tmr;
  logic              locks_ok, lock_full, hold_done, wait_done;
  logic              match, done;

  logic [WORD_W-1:0] tx_data_d;
  logic              align_d, up_d, fail_d, valid_d;

  assign locks_ok  = tx_locked & rx_locked;
  assign lock_full = (lock_cnt == LOCK_W'(LOCK_STABLE - 1));
  assign hold_done = (tmr == TMR_W'(SLIP_HOLD - 1));
  assign wait_done = (tmr == TMR_W'(SLIP_WAIT - 1));
  assign state_o   = state;

  lvds_pattern_check #(
    .WORD_W    (WORD_W),
    .PATTERN   (TRAIN_PAT),
    .CHECK_LEN (CHECK_LEN)
  ) u_check (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != TRAIN),
    .rx_data (rx_data),
    .match   (match),
    .done    (done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Lock loss outranks retrain, and both outrank every normal transition.
  always_comb begin
    next_state = state;
    if (state != IDLE && (!locks_ok || retrain)) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (locks_ok && lock_full) next_state = TRAIN;
        TRAIN: begin
          if (done) begin
            next_state = ALIGNED;
          end else if (!match) begin
            next_state = (slip_count == 5'(MAX_SLIPS)) ? FAIL : SLIP;
          end
        end
        SLIP:     if (hold_done) next_state = SLIPWAIT;
        SLIPWAIT: if (wait_done) next_state = TRAIN;
        ALIGNED:  next_state = ALIGNED;
        FAIL:     next_state = FAIL;
        default:  next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_data_d = (next_state == ALIGNED) ? user_tx_data : TRAIN_PAT;
    align_d   = (next_state == SLIP);
    up_d      = (next_state == ALIGNED);
    fail_d    = (next_state == FAIL);
    valid_d   = (state == ALIGNED) && (next_state == ALIGNED);
  end

  // Lock filter only runs in IDLE, so every return to IDLE restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n || state != IDLE || !locks_ok) begin
      lock_cnt <= '0;
    end else if (!lock_full) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || next_state != state) begin
      tmr <= '0;
    end else if (tmr != '1) begin
      tmr <= tmr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slip_count <= '0;
    end else if (state == IDLE && next_state == TRAIN) begin
      slip_count <= '0;
    end else if (state == TRAIN && next_state == SLIP && slip_count != '1) begin
      slip_count <= slip_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data       <= TRAIN_PAT;
      rx_data_align <= 1'b0;
      link_up       <= 1'b0;
      link_fail     <= 1'b0;
      rx_user_valid <= 1'b0;
      rx_user_data  <= '0;
    end else begin
      tx_data       <= tx_data_d;
      rx_data_align <= align_d;
      link_up       <= up_d;
      link_fail     <= fail_d;
      rx_user_valid <= valid_d;
      if (valid_d) begin
        rx_user_data <= rx_data;
      end
    end
  end

endmodule
